nonce_select: RTL and testbench

Downstream post-processing stage for the multi-nonce SHA-256 hash engine. After the hash engine writes its NUM_NONCES final hash words (H0 of each nonce's second hash) to memory, this block reads them back and compares each against a 32-bit difficulty target. It selects the winning nonce (lowest index whose hash is below target, else the overall minimum) and writes a two-word result record back to memory. It shares the engine's single-port memory bus and runs only after the engine's done.

---
 rtl/nonce_pkg.sv | 27 ++
 rtl/nonce_min_track.sv | 72 +++++++
 rtl/nonce_select.sv | 137 +++++++++++++
 tb/tb_nonce_select.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_pkg.sv
// Shared types and constants for the nonce selection stage.
package nonce_pkg;

  // Scan controller states; the state present on the bus names the state.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    WR0  = 3'd2,
    WR1  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int DEFAULT_NUM_NONCES = 16;

  // Result record layout: word 0 = {found, zeros, index}, word 1 = hash.
  localparam int          FOUND_BIT       = 31;
  localparam logic [15:0] RESULT_HASH_OFS = 16'd1;

  // Build result word 0 from the found flag and a zero-extended index.
  function automatic logic [31:0] pack_status(input logic hit, input logic [30:0] idx);
    logic [31:0] w;
    w            = {1'b0, idx};
    w[FOUND_BIT] = hit;
    return w;
  endfunction

endpackage

// File: rtl/nonce_min_track.sv
// Tracks the first hash below target and the overall minimum hash.
// Outputs are look-ahead: they already include the capture presented this
// cycle, so the controller can emit the result in the same cycle as the last
// capture.
module nonce_min_track #(
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            valid,
  input  logic [IDXW-1:0] idx,
  input  logic [31:0]     hash,
  input  logic [31:0]     target,
  output logic            hit,
  output logic [IDXW-1:0] sel_idx,
  output logic [31:0]     sel_hash
);

  logic            hit_q;
  logic [IDXW-1:0] first_idx_q;
  logic [31:0]     first_hash_q;
  logic [31:0]     best_hash_q;
  logic [IDXW-1:0] best_idx_q;

  logic            qual;
  logic            better;
  logic            hit_n;
  logic [IDXW-1:0] first_idx_n;
  logic [31:0]     first_hash_n;
  logic [31:0]     best_hash_n;
  logic [IDXW-1:0] best_idx_n;

  // Next values: first qualifying hash wins, minimum is strict so ties keep the lower index.
  always_comb begin
    qual         = valid && (hash < target) && !hit_q;
    better       = valid && (hash < best_hash_q);
    hit_n        = hit_q | qual;
    first_idx_n  = qual ? idx : first_idx_q;
    first_hash_n = qual ? hash : first_hash_q;
    best_hash_n  = better ? hash : best_hash_q;
    best_idx_n   = better ? idx : best_idx_q;
  end

  assign hit      = hit_n;
  assign sel_idx  = hit_n ? first_idx_n : best_idx_n;
  assign sel_hash = hit_n ? first_hash_n : best_hash_n;

  // Tracking registers, cleared at the start of every scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q        <= 1'b0;
      first_idx_q  <= '0;
      first_hash_q <= '0;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_idx_q   <= '0;
    end else if (clear) begin
      hit_q        <= 1'b0;
      first_idx_q  <= '0;
      first_hash_q <= '0;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_idx_q   <= '0;
    end else begin
      hit_q        <= hit_n;
      first_idx_q  <= first_idx_n;
      first_hash_q <= first_hash_n;
      best_hash_q  <= best_hash_n;
      best_idx_q   <= best_idx_n;
    end
  end

endmodule

// File: rtl/nonce_select.sv
// Reads back NUM_NONCES hash words, selects the winning nonce and writes a
// two-word result record over the shared single-port memory bus.
// Memory handshake: no valid/ready; an address on mem_addr returns its data
// on mem_read_data one cycle later, and mem_we high writes mem_write_data to
// mem_addr on that rising edge.
module nonce_select
  import nonce_pkg::*;
#(
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES,
  parameter int IDXW       = $clog2(NUM_NONCES)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [15:0]     hash_addr,
  input  logic [15:0]     result_addr,
  input  logic [31:0]     target,
  output logic            done,
  output logic            found,
  output logic [IDXW-1:0] nonce_idx,
  output logic            mem_clk,
  output logic            mem_we,
  output logic [15:0]     mem_addr,
  output logic [31:0]     mem_write_data,
  input  logic [31:0]     mem_read_data,
  output state_t          dbg_state
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_NONCES - 1);

  state_t          state;
  logic [31:0]     target_q;
  logic [IDXW-1:0] rd_cnt;
  logic [IDXW-1:0] cap_cnt;
  logic            cap_live;

  logic            cap_valid;
  logic            last_cap;
  logic            trk_clear;
  logic            sel_hit;
  logic [IDXW-1:0] sel_idx;
  logic [31:0]     sel_hash;

  assign mem_clk   = clk;
  assign dbg_state = state;

  // Read data lags its address by one cycle, so captures start one cycle into SCAN.
  assign cap_valid = (state == SCAN) && cap_live;
  assign last_cap  = cap_valid && (cap_cnt == LAST);
  assign trk_clear = (state == IDLE) && start;

  nonce_min_track #(
    .IDXW(IDXW)
  ) u_track (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (trk_clear),
    .valid    (cap_valid),
    .idx      (cap_cnt),
    .hash     (mem_read_data),
    .target   (target_q),
    .hit      (sel_hit),
    .sel_idx  (sel_idx),
    .sel_hash (sel_hash)
  );

  // Scan controller with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      target_q       <= '0;
      rd_cnt         <= '0;
      cap_cnt        <= '0;
      cap_live       <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      nonce_idx      <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            target_q <= target;
            mem_addr <= hash_addr;
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            cap_live <= 1'b0;
            found    <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          cap_live <= 1'b1;
          if (rd_cnt < LAST) begin
            mem_addr <= mem_addr + 16'd1;
            rd_cnt   <= rd_cnt + 1'b1;
          end
          if (cap_valid) begin
            cap_cnt <= cap_cnt + 1'b1;
          end
          // The last capture is folded into the selection through the look-ahead outputs.
          if (last_cap) begin
            mem_we         <= 1'b1;
            mem_addr       <= result_addr;
            mem_write_data <= pack_status(sel_hit, 31'(sel_idx));
            state          <= WR0;
          end
        end
        WR0: begin
          mem_we         <= 1'b1;
          mem_addr       <= result_addr + RESULT_HASH_OFS;
          mem_write_data <= sel_hash;
          state          <= WR1;
        end
        WR1: begin
          mem_we    <= 1'b0;
          done      <= 1'b1;
          found     <= sel_hit;
          nonce_idx <= sel_idx;
          state     <= FIN;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_select.sv
// Bench for nonce_select: table vectors, random scans against a reference
// model, plus restart-ignore and mid-scan reset sequences.
module tb_nonce_select;
  import nonce_pkg::*;

  localparam int N    = 16;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     hash_addr = '0;
  logic [15:0]     result_addr = '0;
  logic [31:0]     target = '0;
  logic            done;
  logic            found;
  logic [IDXW-1:0] nonce_idx;
  logic            mem_clk;
  logic            mem_we;
  logic [15:0]     mem_addr;
  logic [31:0]     mem_write_data;
  logic [31:0]     mem_read_data = '0;
  state_t          dbg_state;

  // Clock
  always #5 clk = ~clk;

  nonce_select #(.NUM_NONCES(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .hash_addr      (hash_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .nonce_idx      (nonce_idx),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // Memory model: one-cycle read latency; DUT writes are observed by the scan task.
  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_h [N];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        ramp;
    logic [31:0] bg;
    int          s1;
    logic [31:0] v1;
    int          s2;
    logic [31:0] v2;
    logic        exp_found;
    int          exp_idx;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: first hash below target, otherwise lowest index holding the minimum.
  task automatic model(input logic [31:0] tg, output logic f, output int idx, output logic [31:0] w1);
    logic [31:0] mn;
    f = 1'b0; idx = 0; w1 = '0;
    for (int i = 0; i < N; i++) begin
      if (!f && cur_h[i] < tg) begin
        f = 1'b1; idx = i; w1 = cur_h[i];
      end
    end
    if (!f) begin
      mn = 32'hFFFF_FFFF;
      for (int i = 0; i < N; i++) if (cur_h[i] < mn) mn = cur_h[i];
      for (int i = N - 1; i >= 0; i--) if (cur_h[i] == mn) idx = i;
      w1 = mn;
    end
  endtask

  // Runs one scan from cur_h; glitch_cyc >= 0 re-pulses start mid-scan.
  task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg,
                          input logic ef, input int ei, input logic [31:0] ew1, input int glitch_cyc);
    int          cyc;
    int          done_cyc;
    int          nw;
    int          extra;
    logic [31:0] w0;
    logic [15:0] ea;
    for (int i = 0; i < N; i++) mem[ha + 16'(i)] = cur_h[i];
    w0 = 32'(ei);
    w0[31] = ef;
    exp_q = {};
    exp_q.push_back(w0);
    exp_q.push_back(ew1);
    @(negedge clk);
    hash_addr = ha; result_addr = ra; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; done_cyc = -1; nw = 0;
    while (cyc < 60 && done_cyc < 0) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == glitch_cyc);
      if (mem_we) begin
        nw++;
        if (exp_q.size() > 0) begin
          ea = ra + 16'(nw - 1);
          check("wr_addr", 32'(mem_addr), 32'(ea));
          check("wr_data", mem_write_data, exp_q.pop_front());
          check("wr_cycle", 32'(cyc), 32'(N + nw));
        end
      end
      if (done) done_cyc = cyc;
    end
    check("done_cycle", 32'(done_cyc), 32'(N + 3));
    check("write_count", 32'(nw), 32'd2);
    check("found", 32'(found), 32'(ef));
    check("nonce_idx", 32'(nonce_idx), 32'(ei));
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    if (glitch_cyc >= 0) begin
      extra = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (done || mem_we) extra++;
      end
      check("restart_ignored", 32'(extra), 32'd0);
    end
  endtask

  task automatic apply_vec(input int k, input int glitch_cyc);
    for (int i = 0; i < N; i++)
      cur_h[i] = vecs[k].ramp ? (32'(i) * 32'h1000_0000 + 32'h100) : vecs[k].bg;
    if (vecs[k].s1 >= 0) cur_h[vecs[k].s1] = vecs[k].v1;
    if (vecs[k].s2 >= 0) cur_h[vecs[k].s2] = vecs[k].v2;
    run_scan(vecs[k].hash_addr, vecs[k].result_addr, vecs[k].target,
             vecs[k].exp_found, vecs[k].exp_idx, vecs[k].exp_w1, glitch_cyc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_nonce_idx"}, 32'(nonce_idx), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic        ef;
    int          ei;
    logic [31:0] ew1;
    logic [31:0] tg;
    logic [15:0] ha;

    //                hash_addr  result_a   target         ramp  bg             s1  v1             s2  v2          found idx w1
    vecs[0] = '{16'h0100, 16'h0800, 32'h3000_0000, 1'b1, 32'h0,         -1, 32'h0,         -1, 32'h0,      1'b1, 0,  32'h0000_0100};
    vecs[1] = '{16'h0200, 16'h0900, 32'h0000_0010, 1'b0, 32'hFFFF_FFF0,  9, 32'h0000_0005, -1, 32'h0,      1'b1, 9,  32'h0000_0005};
    vecs[2] = '{16'h0300, 16'h0A00, 32'h0000_0000, 1'b0, 32'h8000_0000,  4, 32'h7FFF_FFFF, -1, 32'h0,      1'b0, 4,  32'h7FFF_FFFF};
    vecs[3] = '{16'h0400, 16'h0B00, 32'h0000_0000, 1'b0, 32'hA000_0000,  3, 32'h0000_1234,  7, 32'h1234,   1'b0, 3,  32'h0000_1234};
    vecs[4] = '{16'h0500, 16'h0C00, 32'h0000_0100, 1'b0, 32'h0000_0900,  2, 32'h0000_0100,  6, 32'h00FF,   1'b1, 6,  32'h0000_00FF};
    vecs[5] = '{16'h0600, 16'h0D00, 32'h0000_0030, 1'b0, 32'hF000_0000,  5, 32'h0000_0020, 11, 32'h0010,   1'b1, 5,  32'h0000_0020};
    vecs[6] = '{16'hFFF8, 16'h0100, 32'h0000_0020, 1'b0, 32'h4000_0000, 12, 32'h0000_0010, -1, 32'h0,      1'b1, 12, 32'h0000_0010};
    vecs[7] = '{16'h0700, 16'h0E00, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, -1, 32'h0,         -1, 32'h0,      1'b0, 0,  32'hFFFF_FFFF};

    // Reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors
    for (int k = 0; k < 8; k++) apply_vec(k, -1);

    // start pulsed during SCAN is ignored
    apply_vec(1, 5);

    // Random scans against the reference model
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++)
        cur_h[i] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 4000);
      if ($urandom_range(0, 2) == 0) cur_h[$urandom_range(8, 15)] = cur_h[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       tg = 32'h0;
        1:       tg = $urandom_range(0, 3000);
        2:       tg = $urandom;
        default: tg = 32'hFFFF_FFFF;
      endcase
      ha = 16'($urandom);
      model(tg, ef, ei, ew1);
      run_scan(ha, ha + 16'h0100, tg, ef, ei, ew1, -1);
    end

    // Reset during SCAN, then a full scan
    apply_vec(1, -1);
    for (int i = 0; i < N; i++) mem[16'h2000 + 16'(i)] = 32'h5;
    @(negedge clk);
    hash_addr = 16'h2000; result_addr = 16'h3000; target = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("midscan_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    apply_vec(2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
